// File: rtl/panda_pcap_if.sv
// panda_pcap_if: AXI write-only master bundle used by the position capture block.
// Address, data and response channels.
// 32-bit data, INCR bursts of up to 16 beats.

interface panda_pcap_if;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic        awvalid;
    logic        awready;

    logic [31:0] wdata;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output awaddr, awlen, awvalid,
        input  awready,
        output wdata, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready
    );

    modport slave (
        input  awaddr, awlen, awvalid,
        output awready,
        input  wdata, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/panda_pcap.sv
// panda_pcap: position capture engine.
// On each trigger the selected 32-bit position words are queued into a capture FIFO.
// The FIFO is drained into a DDR ring buffer with AXI write bursts.
// Dropping enable_i flushes the remaining words as a short burst and signals done.
// Build option: define PCAP_TIMESTAMP_EN to prepend a free-running cycle count word
// to every capture record.

module panda_pcap #(
    parameter int FIFO_DEPTH = 256,
    parameter int BURST_LEN  = 16
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         enable_i,
    input  logic         trig_i,
    input  logic [3:0]   mask_i,
    input  logic [127:0] pos_i,
    input  logic [31:0]  dma_addr_i,
    input  logic [15:0]  block_size_i,
    panda_pcap_if.master m_axi,
    output logic [3:0]   irq_o,
    output logic         busy_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(BURST_LEN + 1);
`ifdef PCAP_TIMESTAMP_EN
    localparam int unsigned TS_W = 1;
`else
    localparam int unsigned TS_W = 0;
`endif
    localparam int unsigned NW = 4 + TS_W;
    localparam logic [AW:0] FULL_CNT  = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] BURST_CNT = (AW+1)'(BURST_LEN);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} dma_state_t;

    // Enable edge tracking, flush and halt state
    logic en_q;
    logic en_fall;
    logic en_rise;
    logic flush_q;
    logic halted_q;
    logic done_cond;

    // Capture sequencer
    logic [NW-1:0] pend_q;
    logic [31:0]   word_q [NW];
    logic [NW-1:0] clr_mask;
    logic [31:0]   push_word;
    logic          sel_found;
    logic          seq_busy;
    logic          trig_acc;
    logic          trig_err;

    // Capture FIFO
    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          fifo_full;
    logic          push_ok;
    logic          overflow;
    logic          pop;
    logic [31:0]   head;

    // DMA sequencing
    dma_state_t    state_q;
    dma_state_t    state_d;
    logic          burst_full;
    logic          burst_part;
    logic          start;
    logic          resp_done;
    logic          beat_last;
    logic [BW-1:0] start_beats;
    logic [BW-1:0] beats_q;
    logic [BW-1:0] beat_cnt_q;
    logic [15:0]   offset_q;
    logic [16:0]   off_sum;
    logic          wrap;
    logic [31:0]   awaddr_q;
    logic [3:0]    awlen_q;
    logic [3:0]    irq_q;

`ifdef PCAP_TIMESTAMP_EN
    logic [31:0] ts_q;

    // Free-running cycle counter sampled into each capture record.
    always_ff @(posedge clk_i) begin
        if (reset_i) ts_q <= '0;
        else         ts_q <= ts_q + 32'd1;
    end
`endif

    assign en_fall = en_q & ~enable_i;
    assign en_rise = ~en_q & enable_i;

    assign seq_busy = |pend_q;
    assign trig_acc = trig_i & enable_i & ~halted_q & ~seq_busy;
    assign trig_err = trig_i & enable_i & ~halted_q & seq_busy;

    assign fifo_full = (count == FULL_CNT);
    assign pop       = (state_q == DATA) & m_axi.wready;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
    assign push_ok   = seq_busy & (~fifo_full | pop);
    assign overflow  = seq_busy & fifo_full & ~pop;
    assign head      = mem[rd_ptr];

    assign done_cond = flush_q & ~seq_busy & (count == '0) & (state_q == IDLE);

    // Enable edge detector and flush/halt bookkeeping.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            en_q     <= 1'b0;
            flush_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            en_q <= enable_i;
            if (en_fall)        flush_q <= 1'b1;
            else if (done_cond) flush_q <= 1'b0;
            if (overflow)       halted_q <= 1'b1;
            else if (en_rise)   halted_q <= 1'b0;
        end
    end

    // Pending-slot mask: loaded on an accepted trigger, cleared one slot per push.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pend_q <= '0;
        end else if (overflow) begin
            pend_q <= '0;
        end else if (trig_acc) begin
`ifdef PCAP_TIMESTAMP_EN
            pend_q <= {mask_i, 1'b1};
`else
            pend_q <= mask_i;
`endif
        end else if (seq_busy) begin
            pend_q <= pend_q & ~clr_mask;
        end
    end

    // Record registers hold the trigger-time snapshot while the slots are pushed out.
    always_ff @(posedge clk_i) begin
        if (trig_acc) begin
            for (int unsigned i = 0; i < 4; i++) begin
                word_q[i + TS_W] <= pos_i[32*i +: 32];
            end
`ifdef PCAP_TIMESTAMP_EN
            word_q[0] <= ts_q;
`endif
        end
    end

    // Lowest pending slot goes next, giving timestamp first then ascending positions.
    always_comb begin
        push_word = '0;
        clr_mask  = '0;
        sel_found = 1'b0;
        for (int unsigned i = 0; i < NW; i++) begin
            if (pend_q[i] && !sel_found) begin
                sel_found   = 1'b1;
                push_word   = word_q[i];
                clr_mask[i] = 1'b1;
            end
        end
    end

    // FIFO storage write port.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem[wr_ptr] <= push_word;
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign burst_full  = (count >= BURST_CNT);
    // Short bursts only once the sequencer has drained, so a flush yields one burst.
    assign burst_part  = flush_q & ~seq_busy & (count != '0);
    assign start_beats = burst_full ? BW'(BURST_LEN) : BW'(count);
    assign beat_last   = (beat_cnt_q == beats_q - BW'(1));
    assign off_sum     = 17'(offset_q) + 17'({beats_q, 2'b00});
    assign wrap        = (off_sum >= 17'(block_size_i));

    // DMA state register.
    always_ff @(posedge clk_i) begin
        if (reset_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // DMA next-state and channel handshake outputs.
    always_comb begin
        state_d         = state_q;
        start           = 1'b0;
        resp_done       = 1'b0;
        m_axi.awvalid   = 1'b0;
        m_axi.wvalid    = 1'b0;
        m_axi.wlast     = 1'b0;
        m_axi.bready    = 1'b0;
        case (state_q)
            IDLE: begin
                if (burst_full || burst_part) begin
                    start   = 1'b1;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                m_axi.awvalid = 1'b1;
                if (m_axi.awready) state_d = DATA;
            end
            DATA: begin
                m_axi.wvalid = 1'b1;
                m_axi.wlast  = beat_last;
                if (m_axi.wready && beat_last) state_d = RESP;
            end
            RESP: begin
                m_axi.bready = 1'b1;
                if (m_axi.bvalid) begin
                    resp_done = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Burst descriptor capture, beat counting and ring-buffer offset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            awaddr_q   <= '0;
            awlen_q    <= '0;
            beats_q    <= '0;
            beat_cnt_q <= '0;
            offset_q   <= '0;
        end else begin
            if (start) begin
                awaddr_q   <= dma_addr_i + {16'h0000, offset_q};
                awlen_q    <= 4'(start_beats - BW'(1));
                beats_q    <= start_beats;
                beat_cnt_q <= '0;
            end else if (pop) begin
                beat_cnt_q <= beat_cnt_q + BW'(1);
            end
            if (resp_done) begin
                if (wrap) offset_q <= '0;
                else      offset_q <= off_sum[15:0];
            end
        end
    end

    // Interrupt pulses: wrap, error (busy trigger, overflow, bad response), done.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            irq_q <= '0;
        end else begin
            irq_q[0] <= resp_done & wrap;
            irq_q[1] <= trig_err | overflow | (resp_done & (m_axi.bresp != 2'b00));
            irq_q[2] <= done_cond;
            irq_q[3] <= 1'b0;
        end
    end

    assign m_axi.awaddr = awaddr_q;
    assign m_axi.awlen  = awlen_q;
    assign m_axi.wdata  = (state_q == DATA) ? head : '0;
    assign irq_o        = irq_q;
    assign busy_o       = seq_busy | (count != '0) | (state_q != IDLE) | flush_q;

endmodule

// File: tb/tb_panda_pcap.sv
// tb_panda_pcap: directed phases with random positions, masks, spacing and AXI backpressure.
// The expected word stream, burst lengths, ring offsets and interrupt counts all come
// from a queue-based model of the capture rules.

module tb_panda_pcap;

    logic         clk = 1'b0;
    logic         reset_i;
    logic         enable_i;
    logic         trig_i;
    logic [3:0]   mask_i;
    logic [127:0] pos_i;
    logic [31:0]  dma_addr_i;
    logic [15:0]  block_size_i;
    logic [3:0]   irq_o;
    logic         busy_o;

    panda_pcap_if bus();

    panda_pcap #(.FIFO_DEPTH(256), .BURST_LEN(16)) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .enable_i     (enable_i),
        .trig_i       (trig_i),
        .mask_i       (mask_i),
        .pos_i        (pos_i),
        .dma_addr_i   (dma_addr_i),
        .block_size_i (block_size_i),
        .m_axi        (bus),
        .irq_o        (irq_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;

    // Reference model state
    logic [31:0] exp_q [$];
    int unsigned exp_off  = 0;
    int exp_wrap = 0, exp_err = 0, exp_done = 0;
    int got_wrap = 0, got_err = 0, got_done = 0;
    int seq_free = 0;
    bit halted_m = 1'b0;
    int burst_len = 0, beat_idx = 0, last_awlen = -1, aw_cnt = 0;
    int rdy_mode = 0;    // 0 random, 1 all stalled, 2 address only
    bit bresp_err = 1'b0;
    int aw_before;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One trigger: the model decides acceptance from sequencer occupancy and FIFO room.
    task automatic trigger(input logic [3:0] m);
        logic [31:0] w [4];
        int c, k, avail;
        for (int i = 0; i < 4; i++) begin
            w[i] = $urandom;
            pos_i[32*i +: 32] = w[i];
        end
        mask_i = m;
        trig_i = 1'b1;
        c = cyc + 1;
        if (enable_i && !halted_m) begin
            if (c < seq_free) begin
                exp_err++;
            end else begin
                k = $countones(m);
                seq_free = c + k + 1;
                avail = (rdy_mode == 1) ? 256 - exp_q.size() : 100000;
                for (int i = 0; i < 4; i++) begin
                    if (m[i] && !halted_m) begin
                        if (avail > 0) begin
                            exp_q.push_back(w[i]);
                            avail--;
                        end else begin
                            exp_err++;
                            halted_m = 1'b1;
                        end
                    end
                end
            end
        end
        tick();
        trig_i = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        tick();
        tick();
        while ((busy_o !== 1'b0 || exp_q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_timeout"}, 32'(n < budget), 32'd1);
        repeat (3) tick();
    endtask

    // AXI slave responder and channel monitor: readies chosen first, then the handshake
    // that the next rising edge will perform is scored.
    initial forever begin
        @(negedge clk);
        if (reset_i) begin
            bus.awready = 1'b0;
            bus.wready  = 1'b0;
            bus.bvalid  = 1'b0;
            bus.bresp   = 2'b00;
        end else begin
            case (rdy_mode)
                1: begin bus.awready = 1'b0; bus.wready = 1'b0; end
                2: begin bus.awready = 1'b1; bus.wready = 1'b0; end
                default: begin
                    bus.awready = ($urandom_range(0, 3) != 0);
                    bus.wready  = ($urandom_range(0, 3) != 0);
                end
            endcase
            bus.bresp  = bresp_err ? 2'b10 : 2'b00;
            bus.bvalid = bus.bready && (bus.bvalid || ($urandom_range(0, 1) == 1));

            got_wrap += int'(irq_o[0]);
            got_err  += int'(irq_o[1]);
            got_done += int'(irq_o[2]);
            check("irq3", 32'(irq_o[3]), 32'd0);

            if (bus.awvalid && bus.awready) begin
                burst_len = (exp_q.size() < 16) ? exp_q.size() : 16;
                check("awaddr", bus.awaddr, dma_addr_i + exp_off);
                check("awlen", 32'(bus.awlen), 32'(burst_len - 1));
                last_awlen = int'(bus.awlen);
                beat_idx = 0;
                aw_cnt++;
            end
            if (bus.wvalid && bus.wready) begin
                check("wdata", bus.wdata, (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF);
                check("wlast", 32'(bus.wlast), 32'(beat_idx == burst_len - 1));
                beat_idx++;
            end
            if (bus.bvalid && bus.bready) begin
                exp_off += 4 * burst_len;
                if (exp_off >= block_size_i) begin
                    exp_off = 0;
                    exp_wrap++;
                end
                if (bresp_err) exp_err++;
            end
        end
    end

    initial begin
        #500000;
        $error("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_i      = 1'b1;
        enable_i     = 1'b0;
        trig_i       = 1'b0;
        mask_i       = 4'h0;
        pos_i        = '0;
        dma_addr_i   = 32'h0010_0000;
        block_size_i = 16'd1024;
        repeat (3) tick();

        check("rst_awvalid", 32'(bus.awvalid), 32'd0);
        check("rst_wvalid",  32'(bus.wvalid),  32'd0);
        check("rst_wlast",   32'(bus.wlast),   32'd0);
        check("rst_bready",  32'(bus.bready),  32'd0);
        check("rst_irq",     32'(irq_o),       32'd0);
        check("rst_busy",    32'(busy_o),      32'd0);
        check("rst_awaddr",  bus.awaddr,       32'd0);
        check("rst_awlen",   32'(bus.awlen),   32'd0);
        check("rst_wdata",   bus.wdata,        32'd0);

        reset_i = 1'b0;
        tick();
        enable_i = 1'b1;
        repeat (2) tick();

        // Four full-mask triggers make exactly one 16-beat burst at the base address.
        repeat (4) begin trigger(4'hF); repeat (5) tick(); end
        wait_idle("first_burst", 1000);
        check("first_awlen", 32'(last_awlen), 32'd15);
        check("first_wrap", 32'(got_wrap), 32'(exp_wrap));

        // Sixty more fill the 1 KiB ring; the wrap is followed by a burst at the base.
        repeat (60) begin trigger(4'hF); repeat (5) tick(); end
        wait_idle("ring_fill", 5000);
        check("ring_wrap_cnt", 32'(got_wrap), 32'(exp_wrap));
        check("ring_offset_model", exp_off, 32'd0);
        repeat (4) begin trigger(4'hF); repeat (5) tick(); end
        wait_idle("after_wrap", 1000);
        check("after_wrap_err", 32'(got_err), 32'(exp_err));

        // Sparse mask then enable drop: one 6-beat burst and a done pulse.
        repeat (3) begin trigger(4'b0101); repeat (5) tick(); end
        enable_i = 1'b0;
        exp_done++;
        wait_idle("flush", 1000);
        check("flush_awlen", 32'(last_awlen), 32'd5);
        check("flush_done", 32'(got_done), 32'(exp_done));
        enable_i = 1'b1;
        halted_m = 1'b0;
        tick();

        // Random masks and spacing, including triggers that land on a busy sequencer.
        repeat (30) begin
            trigger(4'($urandom_range(0, 15)));
            repeat ($urandom_range(0, 5)) tick();
        end
        enable_i = 1'b0;
        exp_done++;
        wait_idle("random", 3000);
        check("random_err", 32'(got_err), 32'(exp_err));
        check("random_done", 32'(got_done), 32'(exp_done));
        check("random_wrap", 32'(got_wrap), 32'(exp_wrap));
        enable_i = 1'b1;
        tick();

        // Error response: interrupt raised, offset still advances by one burst.
        bresp_err = 1'b1;
        repeat (4) begin trigger(4'hF); repeat (5) tick(); end
        wait_idle("bresp", 1000);
        bresp_err = 1'b0;
        check("bresp_err", 32'(got_err), 32'(exp_err));
        repeat (4) begin trigger(4'hF); repeat (5) tick(); end
        wait_idle("bresp_next", 1000);

        // Stalled bus: fill the FIFO, overflow halts capture, later triggers ignored.
        rdy_mode = 1;
        repeat (64) begin trigger(4'hF); repeat (5) tick(); end
        check("full_err_before", 32'(got_err), 32'(exp_err));
        repeat (3) begin trigger(4'hF); repeat (5) tick(); end
        check("overflow_err", 32'(got_err), 32'(exp_err));
        check("stall_awvalid", 32'(bus.awvalid), 32'd1);
        check("stall_busy", 32'(busy_o), 32'd1);
        rdy_mode = 0;
        wait_idle("overflow_drain", 8000);
        check("drain_err", 32'(got_err), 32'(exp_err));
        enable_i = 1'b0;
        exp_done++;
        wait_idle("rearm", 200);
        check("rearm_done", 32'(got_done), 32'(exp_done));
        enable_i = 1'b1;
        halted_m = 1'b0;
        tick();

        // Reset in the middle of a data phase abandons the burst.
        rdy_mode = 2;
        repeat (4) begin trigger(4'hF); repeat (5) tick(); end
        repeat (5) tick();
        check("midburst_wvalid", 32'(bus.wvalid), 32'd1);
        reset_i = 1'b1;
        tick();
        check("reset_awvalid", 32'(bus.awvalid), 32'd0);
        check("reset_wvalid",  32'(bus.wvalid),  32'd0);
        check("reset_busy",    32'(busy_o),      32'd0);
        exp_q.delete();
        exp_off  = 0;
        seq_free = 0;
        tick();
        reset_i  = 1'b0;
        rdy_mode = 0;
        aw_before = aw_cnt;
        repeat (40) tick();
        check("post_reset_quiet", 32'(aw_cnt), 32'(aw_before));
        repeat (4) begin trigger(4'hF); repeat (5) tick(); end
        wait_idle("post_reset_burst", 1000);
        check("post_reset_aw", 32'(aw_cnt), 32'(aw_before + 1));
        check("final_err", 32'(got_err), 32'(exp_err));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
